// File: rtl/dg_pkg.sv
// ============================================================================
//  Module      : dg_pkg
//  Description : Shared ureg group codes and index width for the DM address
//                generator.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dg_pkg;

    localparam int DG_IDX_W = 3;

    typedef enum logic [1:0] {
        DG_GRP_I = 2'd0,
        DG_GRP_M = 2'd1,
        DG_GRP_L = 2'd2,
        DG_GRP_B = 2'd3
    } dg_grp_e;

endpackage

`default_nettype wire

// File: rtl/dg_circ_mod.sv
// ============================================================================
//  Module      : dg_circ_mod
//  Description : Combinational modified-index adder with single-correction
//                circular-buffer wrap (active when length is non-zero).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dg_circ_mod #(
    parameter int DMA_SIZE = 17
) (
    input  logic [DMA_SIZE-1:0] idx_i,
    input  logic [DMA_SIZE-1:0] mod_i,
    input  logic [DMA_SIZE-1:0] len_i,
    input  logic [DMA_SIZE-1:0] base_i,
    output logic [DMA_SIZE-1:0] sum_o
);

    logic [DMA_SIZE-1:0] w_sum;
    logic [DMA_SIZE:0]   w_sum_x;
    logic [DMA_SIZE:0]   w_end_x;
    logic [DMA_SIZE:0]   w_base_x;

    // Bounds are compared one bit wider so B+L never overflows the test.
    always_comb begin
        w_sum    = idx_i + mod_i;
        w_sum_x  = {1'b0, w_sum};
        w_base_x = {1'b0, base_i};
        w_end_x  = {1'b0, base_i} + {1'b0, len_i};
        sum_o    = w_sum;
        if (len_i != '0) begin
            if (w_sum_x >= w_end_x) begin
                sum_o = w_sum - len_i;
            end else if (w_sum_x < w_base_x) begin
                sum_o = w_sum + len_i;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/dm_addr_gen.sv
// ============================================================================
//  Module      : dm_addr_gen
//  Description : DM data address generator with I/M/L/B register file,
//                pre/post modify, circular wrap and ureg access.
//                Optional bit-reversed I0 addressing under DG_BITREV_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dm_addr_gen
    import dg_pkg::*;
#(
    parameter int DMA_SIZE = 17,
    parameter int DMD_SIZE = 16,
    parameter int NREG     = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ps_dg_en,
    input  logic                ps_dg_pre,
    input  logic [DG_IDX_W-1:0] ps_dg_ireg,
    input  logic [DG_IDX_W-1:0] ps_dg_mreg,
    input  logic                ps_dg_imm_en,
    input  logic [DMA_SIZE-1:0] ps_dg_imm,
    input  logic                ps_dg_wrt,
    input  logic                ps_dg_rd,
    input  logic [4:0]          ps_dg_radd,
    input  logic [DMD_SIZE-1:0] bc_dt,
`ifdef DG_BITREV_EN
    input  logic                ps_dg_brev,
`endif
    output logic [DMA_SIZE-1:0] dg_dm_add,
    output logic [DMD_SIZE-1:0] dg_bc_dt
);

    logic [DMA_SIZE-1:0] i_q [NREG];
    logic [DMA_SIZE-1:0] m_q [NREG];
    logic [DMA_SIZE-1:0] l_q [NREG];
    logic [DMA_SIZE-1:0] b_q [NREG];
    logic [DMA_SIZE-1:0] i_d [NREG];
    logic [DMA_SIZE-1:0] m_d [NREG];
    logic [DMA_SIZE-1:0] l_d [NREG];
    logic [DMA_SIZE-1:0] b_d [NREG];

    logic [DMA_SIZE-1:0] dm_add_q, dm_add_d;
    logic [DMD_SIZE-1:0] bc_dt_q, bc_dt_d;

    logic [DMA_SIZE-1:0] w_mod;
    logic [DMA_SIZE-1:0] w_wrap;
    logic [DMA_SIZE-1:0] w_addr;
    logic [DMA_SIZE-1:0] w_emit;
    logic [DMA_SIZE-1:0] w_wdata;
    dg_grp_e             w_grp;
    logic [DG_IDX_W-1:0] w_idx;

    assign w_grp   = dg_grp_e'(ps_dg_radd[4:3]);
    assign w_idx   = ps_dg_radd[DG_IDX_W-1:0];
    assign w_wdata = {{(DMA_SIZE-DMD_SIZE){1'b0}}, bc_dt};
    assign w_mod   = ps_dg_imm_en ? ps_dg_imm : m_q[ps_dg_mreg];

    dg_circ_mod #(
        .DMA_SIZE (DMA_SIZE)
    ) u_circ (
        .idx_i  (i_q[ps_dg_ireg]),
        .mod_i  (w_mod),
        .len_i  (l_q[ps_dg_ireg]),
        .base_i (b_q[ps_dg_ireg]),
        .sum_o  (w_wrap)
    );

    assign w_addr = ps_dg_pre ? w_wrap : i_q[ps_dg_ireg];

`ifdef DG_BITREV_EN
    logic [DMA_SIZE-1:0] w_rev;
    for (genvar k = 0; k < DMA_SIZE; k++) begin : g_brev
        assign w_rev[k] = w_addr[DMA_SIZE-1-k];
    end
    // Only the emitted address is reversed; the stored I0 stays linear.
    assign w_emit = (ps_dg_brev && (ps_dg_ireg == '0)) ? w_rev : w_addr;
`else
    assign w_emit = w_addr;
`endif

    always_comb begin
        i_d      = i_q;
        m_d      = m_q;
        l_d      = l_q;
        b_d      = b_q;
        dm_add_d = dm_add_q;
        bc_dt_d  = bc_dt_q;

        if (ps_dg_en) begin
            dm_add_d = w_emit;
            if (!ps_dg_pre) begin
                i_d[ps_dg_ireg] = w_wrap;
            end
        end

        // Applied after the access so a ureg write to the same I wins.
        if (ps_dg_wrt) begin
            case (w_grp)
                DG_GRP_I: i_d[w_idx] = w_wdata;
                DG_GRP_M: m_d[w_idx] = w_wdata;
                DG_GRP_L: l_d[w_idx] = w_wdata;
                DG_GRP_B: b_d[w_idx] = w_wdata;
                default:  ;
            endcase
        end

        if (ps_dg_rd) begin
            case (w_grp)
                DG_GRP_I: bc_dt_d = i_q[w_idx][DMD_SIZE-1:0];
                DG_GRP_M: bc_dt_d = m_q[w_idx][DMD_SIZE-1:0];
                DG_GRP_L: bc_dt_d = l_q[w_idx][DMD_SIZE-1:0];
                DG_GRP_B: bc_dt_d = b_q[w_idx][DMD_SIZE-1:0];
                default:  ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < NREG; k++) begin
                i_q[k] <= '0;
                m_q[k] <= '0;
                l_q[k] <= '0;
                b_q[k] <= '0;
            end
            dm_add_q <= '0;
            bc_dt_q  <= '0;
        end else begin
            i_q      <= i_d;
            m_q      <= m_d;
            l_q      <= l_d;
            b_q      <= b_d;
            dm_add_q <= dm_add_d;
            bc_dt_q  <= bc_dt_d;
        end
    end

    assign dg_dm_add = dm_add_q;
    assign dg_bc_dt  = bc_dt_q;

endmodule

`default_nettype wire

// File: tb/tb_dm_addr_gen.sv
// ============================================================================
//  Module      : tb_dm_addr_gen
//  Description : Directed and randomized bench for dm_addr_gen against an
//                arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dm_addr_gen;

    localparam int C_DMA = 17;
    localparam int C_DMD = 16;
    localparam int C_MODV = 131072;

    logic             clk = 1'b0;
    logic             reset;
    logic             ps_dg_en;
    logic             ps_dg_pre;
    logic [2:0]       ps_dg_ireg;
    logic [2:0]       ps_dg_mreg;
    logic             ps_dg_imm_en;
    logic [C_DMA-1:0] ps_dg_imm;
    logic             ps_dg_wrt;
    logic             ps_dg_rd;
    logic [4:0]       ps_dg_radd;
    logic [C_DMD-1:0] bc_dt;
    logic             ps_dg_brev;
    logic [C_DMA-1:0] dg_dm_add;
    logic [C_DMD-1:0] dg_bc_dt;

    always #5 clk = ~clk;

    dm_addr_gen dut (
        .clk          (clk),
        .reset        (reset),
        .ps_dg_en     (ps_dg_en),
        .ps_dg_pre    (ps_dg_pre),
        .ps_dg_ireg   (ps_dg_ireg),
        .ps_dg_mreg   (ps_dg_mreg),
        .ps_dg_imm_en (ps_dg_imm_en),
        .ps_dg_imm    (ps_dg_imm),
        .ps_dg_wrt    (ps_dg_wrt),
        .ps_dg_rd     (ps_dg_rd),
        .ps_dg_radd   (ps_dg_radd),
        .bc_dt        (bc_dt),
`ifdef DG_BITREV_EN
        .ps_dg_brev   (ps_dg_brev),
`endif
        .dg_dm_add    (dg_dm_add),
        .dg_bc_dt     (dg_bc_dt)
    );

    int n_chk = 0;
    int n_err = 0;

    // Reference state: groups 0..3 = I, M, L, B
    logic [C_DMA-1:0] mdl_reg [4][8];
    logic [C_DMA-1:0] mdl_add;
    logic [C_DMD-1:0] mdl_bc;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [C_DMA-1:0] mdl_wrap(input logic [C_DMA-1:0] iv, mv, lv, bv);
        int s;
        s = (int'(iv) + int'(mv)) % C_MODV;
        if (lv != 0) begin
            if (s >= int'(bv) + int'(lv)) s = s - int'(lv);
            else if (s < int'(bv))       s = s + int'(lv);
        end
        s = s % C_MODV;
        return s[C_DMA-1:0];
    endfunction

    task automatic mdl_reset();
        for (int g = 0; g < 4; g++)
            for (int k = 0; k < 8; k++)
                mdl_reg[g][k] = '0;
        mdl_add = '0;
        mdl_bc  = '0;
    endtask

    task automatic idle_inputs();
        ps_dg_en = 0; ps_dg_pre = 0; ps_dg_ireg = 0; ps_dg_mreg = 0;
        ps_dg_imm_en = 0; ps_dg_imm = 0; ps_dg_wrt = 0; ps_dg_rd = 0;
        ps_dg_radd = 0; bc_dt = 0; ps_dg_brev = 0;
    endtask

    // One clock cycle: drive, predict from pre-edge model, clock, compare.
    task automatic step(input logic en, pre, input logic [2:0] ir, mr,
                        input logic ie, input logic [C_DMA-1:0] imm,
                        input logic wr, rd, input logic [4:0] ra,
                        input logic [C_DMD-1:0] dat, input logic br);
        logic [C_DMA-1:0] modv, w, nadd, rv;
        logic [C_DMD-1:0] nbc;
        ps_dg_en = en; ps_dg_pre = pre; ps_dg_ireg = ir; ps_dg_mreg = mr;
        ps_dg_imm_en = ie; ps_dg_imm = imm; ps_dg_wrt = wr; ps_dg_rd = rd;
        ps_dg_radd = ra; bc_dt = dat; ps_dg_brev = br;
        nadd = mdl_add;
        nbc  = mdl_bc;
        w    = '0;
        if (en) begin
            modv = ie ? imm : mdl_reg[1][mr];
            w    = mdl_wrap(mdl_reg[0][ir], modv, mdl_reg[2][ir], mdl_reg[3][ir]);
            nadd = pre ? w : mdl_reg[0][ir];
`ifdef DG_BITREV_EN
            if (br && ir == 0) begin
                rv = nadd;
                for (int k = 0; k < C_DMA; k++) nadd[k] = rv[C_DMA-1-k];
            end
`endif
        end
        if (rd) begin
            rv  = mdl_reg[ra[4:3]][ra[2:0]];
            nbc = rv[C_DMD-1:0];
        end
        @(posedge clk);
        #1;
        if (en && !pre) mdl_reg[0][ir] = w;
        if (wr) mdl_reg[ra[4:3]][ra[2:0]] = {1'b0, dat};
        mdl_add = nadd;
        mdl_bc  = nbc;
        idle_inputs();
        check_val("dm_add", dg_dm_add, mdl_add);
        check_val("bc_dt", dg_bc_dt, mdl_bc);
    endtask

    task automatic wr_reg(input logic [1:0] g, input logic [2:0] k, input logic [C_DMD-1:0] v);
        step(0, 0, 0, 0, 0, 0, 1, 0, {g, k}, v, 0);
    endtask

    task automatic rd_reg(input logic [1:0] g, input logic [2:0] k);
        step(0, 0, 0, 0, 0, 0, 0, 1, {g, k}, 0, 0);
    endtask

    task automatic acc(input logic pre, input logic [2:0] ir, mr, input logic ie,
                       input logic [C_DMA-1:0] imm);
        step(1, pre, ir, mr, ie, imm, 0, 0, 0, 0, 0);
    endtask

    task automatic rand_steps(input int n);
        for (int t = 0; t < n; t++) begin
            step($urandom_range(0, 1), $urandom_range(0, 1), 3'($urandom), 3'($urandom),
                 $urandom_range(0, 3) == 0, 17'($urandom),
                 $urandom_range(0, 2) == 0, $urandom_range(0, 1),
                 5'($urandom), ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 511)) : 16'($urandom),
                 $urandom_range(0, 1));
        end
    endtask

    initial begin
        idle_inputs();
        mdl_reset();
        reset = 0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_add", dg_dm_add, 0);
        check_val("rst_bc", dg_bc_dt, 0);
        @(negedge clk);
        reset = 1;
        @(posedge clk);
        #1;

        // Linear post-modify
        wr_reg(0, 0, 16'h10);
        wr_reg(1, 0, 16'h4);
        wr_reg(2, 0, 16'h0);
        acc(0, 0, 0, 0, 0);
        check_val("lin_add0", dg_dm_add, 17'h10);
        rd_reg(0, 0);
        check_val("lin_i0a", dg_bc_dt, 16'h14);
        acc(0, 0, 0, 0, 0);
        check_val("lin_add1", dg_dm_add, 17'h14);
        rd_reg(0, 0);
        check_val("lin_i0b", dg_bc_dt, 16'h18);

        // Circular buffer
        wr_reg(3, 1, 16'h100);
        wr_reg(2, 1, 16'h8);
        wr_reg(0, 1, 16'h106);
        wr_reg(1, 1, 16'h3);
        acc(0, 1, 1, 0, 0);
        check_val("circ_a0", dg_dm_add, 17'h106);
        acc(0, 1, 1, 0, 0);
        check_val("circ_a1", dg_dm_add, 17'h101);
        acc(0, 1, 1, 0, 0);
        check_val("circ_a2", dg_dm_add, 17'h104);

        // Pre-modify with negative immediate
        wr_reg(0, 2, 16'h20);
        acc(1, 2, 0, 1, 17'h1FFFE);
        check_val("pre_add", dg_dm_add, 17'h1E);
        rd_reg(0, 2);
        check_val("pre_i2", dg_bc_dt, 16'h20);

        // Post-modify racing a ureg write to the same I
        wr_reg(0, 3, 16'h40);
        wr_reg(1, 4, 16'h1);
        step(1, 0, 3, 4, 0, 0, 1, 0, {2'd0, 3'd3}, 16'h99, 0);
        check_val("race_add", dg_dm_add, 17'h40);
        rd_reg(0, 3);
        check_val("race_i3", dg_bc_dt, 16'h99);

        rd_reg(2, 1);
        check_val("rd_l1", dg_bc_dt, 16'h0008);

        // Same-cycle read and write of one register returns the old value
        step(0, 0, 0, 0, 0, 0, 1, 1, {2'd1, 3'd4}, 16'h55, 0);
        check_val("rdwr_old", dg_bc_dt, 16'h1);

`ifdef DG_BITREV_EN
        wr_reg(0, 0, 16'h1);
        wr_reg(2, 0, 16'h0);
        step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        check_val("brev_add", dg_dm_add, 17'h10000);
        rd_reg(0, 0);
        check_val("brev_i0", dg_bc_dt, 16'h5);
`endif

        rand_steps(400);

        // Asynchronous reset in the middle of an access
        ps_dg_en = 1; ps_dg_pre = 0; ps_dg_ireg = 1; ps_dg_wrt = 1;
        ps_dg_radd = 5'b00001; bc_dt = 16'h1234;
        #2;
        reset = 0;
        #1;
        check_val("arst_add", dg_dm_add, 0);
        check_val("arst_bc", dg_bc_dt, 0);
        mdl_reset();
        @(posedge clk);
        #1;
        idle_inputs();
        @(negedge clk);
        reset = 1;
        @(posedge clk);
        #1;
        rd_reg(0, 1);
        check_val("arst_i1", dg_bc_dt, 0);

        rand_steps(400);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dm_addr_gen.md
Name: dm_addr_gen

Overview:
- Data address generator (DAG) directly upstream of the memory block; its registered output drives dg_dm_add.
- Holds 8 index (I), modify (M), length (L) and base (B) registers, DMA_SIZE bits each.
- On each DM access request from the program sequencer it emits a pre- or post-modified address with optional circular-buffer wrap.
- Registers are written and read over the bc_dt bus as universal registers.

Parameters:
- DMA_SIZE, 17, DM address width; width of every I/M/L/B register.
- DMD_SIZE, 16, bc_dt data bus width.
- NREG, 8, registers per group; index width = clog2(NREG).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-low reset
- ps_dg_en  in  1  DM access request this cycle
- ps_dg_pre  in  1  1 = pre-modify (address = I+M, I unchanged); 0 = post-modify (address = I, I <= I+M)
- ps_dg_ireg  in  3  I/L/B register select
- ps_dg_mreg  in  3  M register select
- ps_dg_imm_en  in  1  use ps_dg_imm instead of M[ps_dg_mreg]
- ps_dg_imm  in  DMA_SIZE  immediate modifier, two's complement
- ps_dg_wrt  in  1  ureg write strobe
- ps_dg_rd  in  1  ureg read strobe
- ps_dg_radd  in  5  ureg address: [4:3] group (0=I, 1=M, 2=L, 3=B), [2:0] index
- bc_dt  in  DMD_SIZE  ureg write data, zero-extended to DMA_SIZE
- dg_dm_add  out  DMA_SIZE  registered DM address
- dg_bc_dt  out  DMD_SIZE  registered ureg readback, low DMD_SIZE bits

Behaviour:
- Reset (async, reset=0): all I/M/L/B = 0; dg_dm_add = 0; dg_bc_dt = 0. Reset mid-access discards the access; no register update.
- Latency: access requested in cycle N. dg_dm_add is valid from the clk edge ending cycle N through cycle N+1. The sequencer asserts ps_dm_cslt in cycle N+1.
- dg_dm_add holds its value when ps_dg_en = 0.
- Modifier mod = ps_dg_imm_en ? ps_dg_imm : M[mreg]. It is signed; the sum I+mod is taken modulo 2^DMA_SIZE.
- Circular wrap applies when L[ireg] != 0:
  - s = I+mod.
  - If s >= B+L, then s -= L.
  - Else if s < B, then s += L.
  - Comparisons are unsigned on DMA_SIZE+1 bits.
  - Correct only for |mod| <= L; larger modifiers give a single correction only (defined, not an error).
- When L = 0, the result is linear I+mod with no wrap.
- Pre-modify: dg_dm_add <= wrap(I+mod); I is not written.
- Post-modify: dg_dm_add <= I; I <= wrap(I+mod).
- Ureg write (ps_dg_wrt): the selected register is loaded at the clock edge.
  - Writing L or B does not alter I.
  - Writing I also does not modify B.
- Ureg read (ps_dg_rd): dg_bc_dt <= selected register[DMD_SIZE-1:0] one cycle later; otherwise dg_bc_dt holds.
- Same-cycle access and write:
  - The access uses pre-edge register values (old I, M, L, B).
  - If the write targets the I being post-modified, the ureg write wins.
- Same-cycle read and write of the same register: the read returns the old value.
- ps_dg_wrt and ps_dg_rd together on different registers: both are performed.
- Back-to-back accesses on the same I: each sees the updated I from the previous edge; no stall.

Optional Feature:
- Macro DG_BITREV_EN.
- Defined:
  - Adds input ps_dg_brev (1 bit).
  - When ps_dg_brev = 1 and ireg = 0, the address emitted on dg_dm_add is bit-reversed over DMA_SIZE bits, for FFT addressing.
  - The stored I0 update remains linear/circular and is not reversed.
- Undefined: the port is absent and addresses are never reversed.

Decomposition:
- Package dg_pkg:
  - ureg group codes DG_GRP_I=0, DG_GRP_M=1, DG_GRP_L=2, DG_GRP_B=3.
  - DG_IDX_W=3.
- Sub-module dg_circ_mod: combinational; inputs I, mod, L, B; output the wrapped sum. It is instantiated once.

Test Plan:
- Reset, then write I0=0x10 and M0=0x4 with L0=0; post-modify access -> dg_dm_add=0x10 next cycle and I0=0x14. Repeat the access -> 0x14, then I0=0x18.
- B1=0x100, L1=0x8, I1=0x106, M1=0x3; three post-modify accesses -> addresses 0x106, 0x101, 0x104.
- Pre-modify with I2=0x20 and imm=-2 (0x1FFFE) -> dg_dm_add=0x1E; I2 stays 0x20.
- Post-modify on I3=0x40, M=1, with same-cycle ureg write I3=0x99 -> address 0x40; I3=0x99 afterwards.
- Ureg read of L1 after it is written with 0x8 -> dg_bc_dt=0x0008 one cycle later. Async reset asserted mid-sequence -> dg_dm_add=0 and dg_bc_dt=0 immediately.
- With DG_BITREV_EN, I0=0x00001 and ps_dg_brev=1 -> dg_dm_add=0x10000.
